// File: rtl/mapper_flit_receiver.sv
// mapper_flit_receiver: keeps local flits, loads keyword table, queues text words in a FWFT FIFO.
// Optional BCAST_ACCEPT_EN also accepts scheduler broadcast dest 4'b0001.
module mapper_flit_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int FLIT_WIDTH = 36,
  parameter logic [3:0] LOCAL_ADDR = 4'b1001,
  parameter int MAX_KEYWORDS = 8,
  parameter int KW_AW = 3,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enablein,
  input  logic [FLIT_WIDTH-1:0] flitin,
  input  logic                  text_ready,
  input  logic [KW_AW-1:0]      kw_rd_addr,
  output logic [DATA_WIDTH-1:0] kw_rd_data,
  output logic [DATA_WIDTH-1:0] kw_count,
  output logic                  kw_valid,
  output logic [DATA_WIDTH-1:0] text_data,
  output logic                  text_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  done,
  output logic                  overflow,
  output logic                  proto_err
);
  typedef enum logic [1:0] {S_COUNT, S_KEY, S_TEXT, S_DONE} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] kw_table [MAX_KEYWORDS];
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] payload, idx;
  logic [ADDR_WIDTH-1:0] wr_p, rd_p;
  logic [ADDR_WIDTH:0] cnt;
  logic acc, marker, push, pop, push_ok, key_word, kw_in_range;
  assign payload = flitin[FLIT_WIDTH-1:4];
  assign marker = payload == '1;
`ifdef BCAST_ACCEPT_EN
  assign acc = enablein && (flitin[3:0] == LOCAL_ADDR || flitin[3:0] == 4'b0001);
`else
  assign acc = enablein && flitin[3:0] == LOCAL_ADDR;
`endif
  assign key_word = acc && state == S_KEY && !marker;
  assign kw_in_range = idx < DATA_WIDTH'(MAX_KEYWORDS);
  assign empty = cnt == '0;
  assign full = cnt == (ADDR_WIDTH+1)'(FIFO_DEPTH);
  assign text_valid = !empty;
  assign text_data = fifo_mem[rd_p];
  assign kw_rd_data = kw_table[kw_rd_addr];
  assign done = state == S_DONE;
  assign pop = text_ready && !empty;
  assign push = acc && state == S_TEXT && !marker;
  assign push_ok = push && (!full || pop);
  always_comb begin
    state_nx = state;
    if (acc)
      case (state)
        S_COUNT: state_nx = marker ? S_DONE : (payload == '0 ? S_TEXT : S_KEY);
        S_KEY:   state_nx = marker ? S_DONE : (idx == kw_count - 1'b1 ? S_TEXT : S_KEY);
        S_TEXT:  state_nx = marker ? S_DONE : S_TEXT;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_COUNT;
      kw_count <= '0;
      idx <= '0;
      kw_valid <= 1'b0;
      overflow <= 1'b0;
      proto_err <= 1'b0;
      wr_p <= '0;
      rd_p <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (acc && state == S_COUNT && !marker) begin
        kw_count <= payload;
        idx <= '0;
      end
      if (key_word) idx <= idx + 1'b1;
      if ((key_word && !kw_in_range) || (acc && marker && (state == S_COUNT || state == S_KEY)))
        proto_err <= 1'b1;
      if (state_nx == S_TEXT && state != S_TEXT) kw_valid <= 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (push_ok) wr_p <= wr_p + 1'b1;
      if (pop) rd_p <= rd_p + 1'b1;
      cnt <= cnt + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop);
    end
  end
  // storage needs no reset; contents are qualified by kw_count and cnt
  always_ff @(posedge clk) begin
    if (!reset && key_word && kw_in_range) kw_table[idx[KW_AW-1:0]] <= payload;
    if (!reset && push_ok) fifo_mem[wr_p] <= payload;
  end
endmodule

// File: tb/tb_mapper_flit_receiver.sv
// tb_mapper_flit_receiver: randomized job streams checked against a queue-based job model.
module tb_mapper_flit_receiver;
  localparam logic [3:0] LOC = 4'b1001;
  localparam logic [31:0] MARK = 32'hFFFF_FFFF;
`ifdef BCAST_ACCEPT_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif
  logic clk = 0, reset = 0, enablein = 0, text_ready = 0;
  logic [35:0] flitin = '0;
  logic [2:0] kw_rd_addr = '0;
  logic [31:0] kw_rd_data, kw_count, text_data;
  logic kw_valid, text_valid, full, empty, done, overflow, proto_err;
  int n_tests = 0, n_fail = 0;
  int m_phase;
  logic [31:0] m_k;
  logic [31:0] m_kw[$], m_q[$];
  bit m_ovf, m_perr, m_done, m_kvalid;

  mapper_flit_receiver dut (.clk(clk), .reset(reset), .enablein(enablein), .flitin(flitin),
    .text_ready(text_ready), .kw_rd_addr(kw_rd_addr), .kw_rd_data(kw_rd_data), .kw_count(kw_count),
    .kw_valid(kw_valid), .text_data(text_data), .text_valid(text_valid), .full(full), .empty(empty),
    .done(done), .overflow(overflow), .proto_err(proto_err));

  always #5 clk = ~clk;

  function automatic logic [3:0] noise_dest();
    logic [3:0] d;
    do d = 4'($urandom); while (d == LOC || d == 4'b0001);
    return d;
  endfunction

  // job model: count word, K keywords, text words, end marker
  task automatic cycle(input bit en, input logic [3:0] d, input logic [31:0] p, input bit r);
    bit acc, pop, push_word;
    enablein = en; flitin = {p, d}; text_ready = r;
    @(posedge clk);
    acc = en && (d == LOC || (BCAST && d == 4'b0001));
    pop = r && m_q.size() > 0;
    push_word = 0;
    if (acc) begin
      if (p == MARK && m_phase < 2) begin m_phase = 3; m_done = 1; m_perr = 1; end
      else if (p == MARK && m_phase == 2) begin m_phase = 3; m_done = 1; end
      else if (m_phase == 0) begin
        m_k = p; m_kw.delete();
        if (p == 0) begin m_phase = 2; m_kvalid = 1; end else m_phase = 1;
      end else if (m_phase == 1) begin
        m_kw.push_back(p);
        if (m_kw.size() > 8) m_perr = 1;
        if (32'(m_kw.size()) == m_k) begin m_phase = 2; m_kvalid = 1; end
      end else if (m_phase == 2) push_word = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (push_word) begin
      if (m_q.size() < 64) m_q.push_back(p); else m_ovf = 1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; enablein = 1; flitin = {32'd3, LOC}; text_ready = 1;
    @(posedge clk); #1;
    reset = 0; enablein = 0; text_ready = 0;
    m_phase = 0; m_k = 0; m_kw.delete(); m_q.delete();
    m_ovf = 0; m_perr = 0; m_done = 0; m_kvalid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({kw_count, kw_valid, done, overflow, proto_err, text_valid, empty, full} !== {32'd0, 7'b0000010}) begin
      n_fail++;
      $display("FAIL reset_state got kw_count=%0h kv=%b done=%b ovf=%b perr=%b tv=%b empty=%b full=%b want 0,0,0,0,0,0,1,0",
               kw_count, kw_valid, done, overflow, proto_err, text_valid, empty, full);
    end
  endtask

  task automatic test_basic(input logic [3:0] d);
    logic [31:0] a, b;
    logic [31:0] s[$];
    a = $urandom & 32'h7FFF_FFFF; b = $urandom & 32'h7FFF_FFFF;
    do_reset();
    s = '{32'd2, a, b, 32'd5, 32'd6, 32'd7, MARK};
    foreach (s[i]) begin
      cycle(1, d, s[i], 0);
      if ($urandom_range(1)) cycle(1, noise_dest(), $urandom, 0);
    end
    n_tests++;
    if (kw_count !== m_k) begin n_fail++; $display("FAIL basic_kw_count d=%h got %0h want %0h", d, kw_count, m_k); end
    n_tests++;
    if ({kw_valid, done, overflow, proto_err, empty} !== {m_kvalid, m_done, m_ovf, m_perr, m_q.size() == 0}) begin
      n_fail++;
      $display("FAIL basic_flags d=%h got kv=%b done=%b ovf=%b perr=%b empty=%b want %b %b %b %b %b", d,
               kw_valid, done, overflow, proto_err, empty, m_kvalid, m_done, m_ovf, m_perr, m_q.size() == 0);
    end
    for (int i = 0; i < m_kw.size() && i < 8; i++) begin
      kw_rd_addr = 3'(i); #1;
      n_tests++;
      if (kw_rd_data !== m_kw[i]) begin n_fail++; $display("FAIL basic_table[%0d] got %0h want %0h", i, kw_rd_data, m_kw[i]); end
    end
    while (m_q.size() > 0) begin
      n_tests++;
      if (text_data !== m_q[0] || text_valid !== 1'b1) begin
        n_fail++; $display("FAIL basic_pop got %0h tv=%b want %0h", text_data, text_valid, m_q[0]);
      end
      cycle(0, 0, 0, 1);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(1, LOC, 0, 0);
    for (int i = 1; i <= 70; i++) begin
      cycle(1, LOC, 32'(i), 0);
      if (i == 64 || i == 70) begin
        n_tests++;
        if (full !== 1'b1 || overflow !== (i == 70)) begin
          n_fail++; $display("FAIL overflow_full word=%0d got full=%b ovf=%b want 1 %b", i, full, overflow, i == 70);
        end
      end
    end
    for (int i = 1; i <= 64; i++) begin
      n_tests++;
      if (text_data !== m_q[0] || text_data !== 32'(i)) begin
        n_fail++; $display("FAIL overflow_pop got %0h want %0h", text_data, i);
      end
      cycle(0, 0, 0, 1);
    end
    n_tests++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_end got empty=%b ovf=%b want 1 1", empty, overflow); end
  endtask

  task automatic test_too_many();
    do_reset();
    cycle(1, LOC, 10, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, LOC, $urandom & 32'h7FFF_FFFF, 0);
      if (i >= 8) begin
        n_tests++;
        if (kw_valid !== m_kvalid || proto_err !== m_perr) begin
          n_fail++; $display("FAIL toomany_flags kw=%0d got kv=%b perr=%b want %b %b", i, kw_valid, proto_err, m_kvalid, m_perr);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      kw_rd_addr = 3'(i); #1;
      n_tests++;
      if (kw_rd_data !== m_kw[i]) begin n_fail++; $display("FAIL toomany_table[%0d] got %0h want %0h", i, kw_rd_data, m_kw[i]); end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    cycle(1, LOC, 0, 0);
    for (int i = 0; i < 64; i++) cycle(1, LOC, $urandom & 32'h7FFF_FFFF, 0);
    for (int i = 0; i < 100; i++) begin
      cycle(1, LOC, $urandom & 32'h7FFF_FFFF, 1);
      n_tests++;
      if (full !== 1'b1 || overflow !== 1'b0 || text_data !== m_q[0]) begin
        n_fail++; $display("FAIL fullpop i=%0d got full=%b ovf=%b head=%0h want 1 0 %0h", i, full, overflow, text_data, m_q[0]);
      end
    end
    while (m_q.size() > 0) begin
      n_tests++;
      if (text_data !== m_q[0]) begin n_fail++; $display("FAIL fullpop_drain got %0h want %0h", text_data, m_q[0]); end
      cycle(0, 0, 0, 1);
    end
  endtask

  task automatic test_bcast_reset();
    do_reset();
    cycle(1, 4'b0001, 32'd3, 0);
    cycle(1, 4'b0001, 32'h1234, 0);
    n_tests++;
    if (kw_count !== m_k) begin n_fail++; $display("FAIL bcast_kw_count got %0h want %0h", kw_count, m_k); end
    cycle(1, LOC, 32'd3, 0);
    cycle(1, LOC, 32'hABCD, 0);
    do_reset();
    n_tests++;
    if ({kw_count, kw_valid, done, overflow, proto_err, text_valid, empty, full} !== {32'd0, 7'b0000010}) begin
      n_fail++; $display("FAIL midkey_reset got kw_count=%0h kv=%b done=%b perr=%b empty=%b", kw_count, kw_valid, done, proto_err, empty);
    end
    cycle(1, LOC, 32'd2, 0);
    cycle(1, LOC, MARK, 0);
    cycle(1, LOC, 32'd9, 0);
    n_tests++;
    if ({done, proto_err, kw_valid, empty} !== 4'b1101) begin
      n_fail++; $display("FAIL early_marker got done=%b perr=%b kv=%b empty=%b want 1 1 0 1", done, proto_err, kw_valid, empty);
    end
  endtask

  task automatic test_random_jobs();
    logic [31:0] s[$];
    int k, t;
    for (int j = 0; j < 4; j++) begin
      do_reset();
      k = $urandom_range(9); t = $urandom_range(90);
      s = '{32'(k)};
      for (int i = 0; i < k + t; i++) s.push_back($urandom & 32'h7FFF_FFFF);
      s.push_back(MARK);
      s.push_back(32'd77);
      while (s.size() > 0 || m_q.size() > 0) begin
        if (s.size() > 0 && $urandom_range(3) != 0) cycle(1, LOC, s.pop_front(), $urandom_range(1));
        else cycle($urandom_range(1), noise_dest(), $urandom, $urandom_range(1));
        n_tests++;
        if ({text_valid, empty, full} !== {m_q.size() > 0, m_q.size() == 0, m_q.size() == 64} ||
            (m_q.size() > 0 && text_data !== m_q[0])) begin
          n_fail++; $display("FAIL rand_fifo job=%0d got tv=%b full=%b head=%0h want size=%0d", j, text_valid, full, text_data, m_q.size());
        end
        n_tests++;
        if ({kw_valid, done, overflow, proto_err} !== {m_kvalid, m_done, m_ovf, m_perr} || kw_count !== m_k) begin
          n_fail++; $display("FAIL rand_flags job=%0d got kv=%b done=%b ovf=%b perr=%b cnt=%0h want %b %b %b %b %0h", j,
                             kw_valid, done, overflow, proto_err, kw_count, m_kvalid, m_done, m_ovf, m_perr, m_k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(LOC);
    test_basic(4'b0110);
    test_basic(4'b0000);
    test_overflow();
    test_too_many();
    test_full_pop();
    test_bcast_reset();
    test_random_jobs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
